// File: rtl/histo_pkg.sv
// Shared widths and FSM encoding for the histogram streamer and the
// threshold-side accumulators that consume its bin stream.
package histo_pkg;

  localparam int PIX_W_DEF    = 8;
  localparam int CNT_W_DEF    = 32;
  localparam int NUM_BINS_DEF = 2 ** PIX_W_DEF;

  // Cycles spent in DRAIN so that in-flight read-modify-writes retire
  // before the stream starts reading the RAM.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/histo_ram.sv
// Histogram bin storage: 1 write port, 1 registered read port.
// A read that collides with a write to the same address returns the old data;
// the parent forwards the in-flight value to cover that hazard.
module histo_ram
  import histo_pkg::*;
#(
  parameter int ADDR_W = PIX_W_DEF,
  parameter int DATA_W = CNT_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One write and one synchronous read per cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/histogram_bin_streamer.sv
// Per-frame intensity histogram builder and bin-by-bin transmitter.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_CLEAR  | zero RAM addresses 0..NUM_BINS-1, one per cycle
//   ST_ACCUM  | accept pixels, read-modify-write their bins
//   ST_DRAIN  | hold off pixels while the last increments retire
//   ST_STREAM | read bins 0..NUM_BINS-1, emit (i, n_i, valid), then done
module histogram_bin_streamer
  import histo_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NUM_BINS = 2 ** PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix,
  output logic             pix_ready,
  input  logic             stream_start,
  output logic [PIX_W-1:0] i,
  output logic [CNT_W-1:0] n_i,
  output logic             valid,
  output logic             last,
  output logic             done,
  output logic [CNT_W-1:0] total_pixels
);

  localparam logic [PIX_W-1:0] LAST_BIN = PIX_W'(NUM_BINS - 1);
  localparam int               DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state, state_nxt;

  logic [PIX_W-1:0]   clr_addr;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_tc;
  logic               accept;

  // Read-modify-write pipe: S1 holds the bin whose read is in flight,
  // S2 holds the bin written on the previous cycle (forwarding source).
  logic               s1_valid;
  logic [PIX_W-1:0]   s1_addr;
  logic [CNT_W-1:0]   s1_data;
  logic [CNT_W-1:0]   s1_inc;
  logic               s2_valid;
  logic [PIX_W-1:0]   s2_addr;
  logic [CNT_W-1:0]   s2_data;

  logic               rd_en;
  logic [PIX_W-1:0]   rd_addr;

  logic               ram_we;
  logic [PIX_W-1:0]   ram_waddr;
  logic [CNT_W-1:0]   ram_wdata;
  logic [PIX_W-1:0]   ram_raddr;
  logic [CNT_W-1:0]   ram_rdata;

  logic               valid_q;
  logic               last_q;
  logic               done_q;
  logic [PIX_W-1:0]   i_q;
  logic [CNT_W-1:0]   total_q;

  assign accept   = pix_valid && (state == ST_ACCUM);
  assign drain_tc = (drain_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CLEAR:  if (clr_addr == LAST_BIN) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (stream_start)         state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_tc)             state_nxt = ST_STREAM;
      ST_STREAM: if (done_q)               state_nxt = ST_CLEAR;
      default:                             state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode; bin outputs are zero whenever valid is low.
  always_comb begin
    pix_ready    = (state == ST_ACCUM);
    valid        = valid_q;
    last         = last_q;
    done         = done_q;
    i            = i_q;
    n_i          = valid_q ? ram_rdata : '0;
    total_pixels = total_q;
  end

  // Clear address sweeps the RAM while in CLEAR and parks at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset || state != ST_CLEAR) clr_addr <= '0;
    else                            clr_addr <= clr_addr + 1'b1;
  end

  // Drain timer: down-counter loaded when the stream request is honoured.
  always_ff @(posedge clk) begin
    if (reset)                                 drain_cnt <= '0;
    else if (state == ST_ACCUM && stream_start) drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
    else if (state == ST_DRAIN && !drain_tc)    drain_cnt <= drain_cnt - 1'b1;
  end

  // Forward the just-written value when the same bin is read back-to-back.
  always_comb begin
    s1_data = (s2_valid && s2_addr == s1_addr) ? s2_data : ram_rdata;
    s1_inc  = (s1_data == CNT_MAX) ? s1_data : s1_data + 1'b1;
  end

  // RMW pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= accept;
      s1_addr  <= pix;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= s1_inc;
    end
  end

  // RAM port muxing: CLEAR owns the write port, otherwise the RMW pipe does.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_addr;
    ram_wdata = s1_inc;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end else if (s1_valid) begin
      ram_we    = 1'b1;
    end
    ram_raddr = (state == ST_STREAM) ? rd_addr : pix;
  end

  // Stream read sequencer: one bin address per cycle, 0..NUM_BINS-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else if (state == ST_DRAIN && drain_tc) begin
      rd_en   <= 1'b1;
      rd_addr <= '0;
    end else if (rd_en) begin
      if (rd_addr == LAST_BIN) rd_en   <= 1'b0;
      else                     rd_addr <= rd_addr + 1'b1;
    end
  end

  // Output qualifiers trail the read by one cycle to line up with RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
    end else begin
      valid_q <= rd_en;
      last_q  <= rd_en && (rd_addr == LAST_BIN);
      done_q  <= last_q;
      i_q     <= rd_en ? rd_addr : '0;
    end
  end

  // Saturating frame pixel count, held through DRAIN and STREAM.
  always_ff @(posedge clk) begin
    if (reset || state == ST_CLEAR)       total_q <= '0;
    else if (accept && total_q != CNT_MAX) total_q <= total_q + 1'b1;
  end

  histo_ram #(
    .ADDR_W (PIX_W),
    .DATA_W (CNT_W),
    .DEPTH  (NUM_BINS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

endmodule

// File: doc/histogram_bin_streamer.md
Name: histogram_bin_streamer

Overview:
- Builds a per-frame intensity histogram from a pixel stream.
- On command, transmits the histogram bin-by-bin as (i, n_i, valid), one bin per cycle, bin 0 first.
- This is the transmitting end of the bin interface consumed by the threshold-side accumulators (background/foreground intensity sums, weight sums).
- Sits between the pixel source and the thresholding datapath, and self-clears for the next frame after each transmission.

Parameters:
- PIX_W, 8, pixel/bin-index width.
- CNT_W, 32, bin count width (n_i).
- NUM_BINS, 2**PIX_W, number of histogram bins.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- pix_valid, input, 1, pixel qualifier.
- pix, input, PIX_W, pixel intensity.
- pix_ready, output, 1, high only in ACCUM; pixels are counted only when pix_valid & pix_ready.
- stream_start, input, 1, single-cycle request to transmit the histogram; honoured only in ACCUM.
- i, output, PIX_W, current bin index.
- n_i, output, CNT_W, count for bin i.
- valid, output, 1, qualifies i/n_i.
- last, output, 1, high with valid on bin NUM_BINS-1.
- done, output, 1, one-cycle pulse the cycle after last.
- total_pixels, output, CNT_W, pixels counted this frame (saturating); held through STREAM.

Behaviour:
- Reset (synchronous, active-high): state <= CLEAR, clear address <= 0. All outputs are 0: i, n_i, valid, last, done, pix_ready, total_pixels.
- Storage: NUM_BINS x CNT_W RAM with synchronous read (1-cycle latency) and one write per cycle.
- CLEAR state:
  - Writes 0 to addresses 0..NUM_BINS-1, one per cycle (NUM_BINS cycles).
  - pix_ready = 0; total_pixels <= 0.
  - Goes to ACCUM after address NUM_BINS-1 is written.
- ACCUM state:
  - pix_ready = 1.
  - Each accepted pixel enters a 2-stage read-modify-write pipe. S1 issues the RAM read at pix. S2 writes data+1.
  - Increments saturate at 2**CNT_W-1.
  - If the S1 address equals the S2 address, S1 takes S2's write value (forwarding). Back-to-back identical pixels must count exactly.
  - total_pixels increments per accepted pixel and saturates.
  - stream_start sampled at cycle T: a pixel accepted in the same cycle is counted. Then ACCUM -> DRAIN.
- DRAIN state:
  - Lasts 2 cycles (T+1, T+2) with pix_ready = 0, so in-flight writes retire.
  - Then -> STREAM.
- STREAM state:
  - Read address runs 0..NUM_BINS-1, one per cycle, starting at T+3.
  - Registered outputs: valid = 1 from T+4 for exactly NUM_BINS consecutive cycles. Output i = k comes one cycle after read k; n_i = RAM[k].
  - No backpressure; valid never drops mid-stream.
  - last = 1 on i = NUM_BINS-1. done = 1 for one cycle at T+4+NUM_BINS; valid = 0 that cycle.
  - Then -> CLEAR for the next frame.
- Ignored inputs:
  - pix_valid is ignored when pix_ready = 0.
  - stream_start is ignored outside ACCUM; a repeat stream_start during DRAIN/STREAM has no effect.
- Outputs when not streaming: i and n_i are 0 whenever valid = 0.
- Reset mid-operation (any state): immediate return to CLEAR. Any partial stream is aborted with no done pulse, and the histogram is re-zeroed.
- Empty frame: stream_start with no pixels streams NUM_BINS zeros; total_pixels = 0.
- Width rules: n_i is full CNT_W. No truncation except saturation.

Decomposition:
- Shared package histo_pkg: PIX_W, CNT_W and NUM_BINS defaults; state enum {CLEAR, ACCUM, DRAIN, STREAM}. The receiving accumulators import the same widths.
- One sub-module: histo_ram (NUM_BINS x CNT_W, 1R1W, synchronous read, read-during-write returns old data). Forwarding lives in the parent.

Test Plan:
- Reset then idle: pix_ready rises exactly NUM_BINS=256 cycles after reset deasserts. All outputs stay 0 until then.
- Pixels 0,0,0,5,255,5, each on back-to-back cycles, then stream_start:
  - valid asserts 4 cycles after stream_start and stays high for 256 cycles.
  - n_i = 3 at i=0, 2 at i=5, 1 at i=255, 0 elsewhere.
  - last on i=255, then done pulse. total_pixels = 6.
- Pixel 7 in the same cycle as stream_start: counted, so n_i(7) = 1. pix_valid during DRAIN/STREAM is ignored.
- stream_start with no pixels: 256 zero-count bins; done pulses. A next-frame pixel 9 streams n_i(9) = 1 only, proving the auto-clear.
- Reset asserted at bin i=100 during STREAM:
  - valid drops next cycle and no done pulse.
  - The subsequent CLEAR takes 256 cycles and the re-streamed histogram is all zero.
- Saturation, with CNT_W overridden to 4: 20 pixels of value 3 give n_i(3) = 15 and total_pixels = 15.
